// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned CMD_MUL_INC = 9;
  localparam int unsigned CMD_MUL_SHL = 10;
  localparam int unsigned FLAGS_W     = 6;

  // Response flag bundle, MSB first: {err, oflow, cout, g, l, e}
  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } flags_t;

  // Multiplier commands take the long ALU latency
  function automatic logic is_mul(input logic mode, input logic [31:0] cmd);
    return mode && ((cmd == 32'(CMD_MUL_INC)) || (cmd == 32'(CMD_MUL_SHL)));
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, with wrap-around.
module alu_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the nearest valid requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % int'(NREQ));
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin accept, issue, wait the
// command latency, return a one-cycle response to the winner.
// Optional macro ALU_ARB_PRIO_EN: requester 0 preempts round-robin (ptr untouched).
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_mode,
  input  logic [NREQ*CMD_W-1:0]    req_cmd,
  input  logic [NREQ*2-1:0]        req_inp_valid,
  input  logic [NREQ*DATA_W-1:0]   req_opa,
  input  logic [NREQ*DATA_W-1:0]   req_opb,
  input  logic [NREQ-1:0]          req_cin,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W:0]          rsp_res,
  output logic [FLAGS_W-1:0]       rsp_flags,
  output logic                     alu_ce,
  output logic                     alu_mode,
  output logic                     alu_cin,
  output logic [1:0]               alu_inp_valid,
  output logic [CMD_W-1:0]         alu_cmd,
  output logic [DATA_W-1:0]        alu_opa,
  output logic [DATA_W-1:0]        alu_opb,
  input  logic [DATA_W:0]          alu_res,
  input  logic                     alu_err,
  input  logic                     alu_oflow,
  input  logic                     alu_cout,
  input  logic                     alu_g,
  input  logic                     alu_l,
  input  logic                     alu_e
);

  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      id_q, id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  alu_ce_q, alu_ce_d;
  logic                  alu_mode_q, alu_mode_d;
  logic                  alu_cin_q, alu_cin_d;
  logic [1:0]            alu_inp_valid_q, alu_inp_valid_d;
  logic [CMD_W-1:0]      alu_cmd_q, alu_cmd_d;
  logic [DATA_W-1:0]     alu_opa_q, alu_opa_d;
  logic [DATA_W-1:0]     alu_opb_q, alu_opb_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]       rsp_res_q, rsp_res_d;
  flags_t                rsp_flags_q, rsp_flags_d;

  logic [NREQ-1:0]       rr_gnt, sel_gnt;
  logic [IDX_W-1:0]      rr_idx, sel_idx;
  logic                  rr_any, sel_any, sel_prio;
  flags_t                flags_in;

  assign flags_in = '{err: alu_err, oflow: alu_oflow, cout: alu_cout,
                      g: alu_g, l: alu_l, e: alu_e};

  alu_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // Final grant selection: optional fixed priority for requester 0
  always_comb begin
    sel_gnt  = rr_gnt;
    sel_idx  = rr_idx;
    sel_any  = rr_any;
    sel_prio = 1'b0;
`ifdef ALU_ARB_PRIO_EN
    if (req_valid[0]) begin
      sel_gnt  = NREQ'(1);
      sel_idx  = '0;
      sel_any  = 1'b1;
      sel_prio = 1'b1;
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    alu_ce_d        = alu_ce_q;
    alu_mode_d      = alu_mode_q;
    alu_cin_d       = alu_cin_q;
    alu_inp_valid_d = alu_inp_valid_q;
    alu_cmd_d       = alu_cmd_q;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;
    rsp_res_d       = rsp_res_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_valid_d     = '0;
    req_ready       = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          req_ready       = sel_gnt;
          id_d            = sel_idx;
          if (!sel_prio) ptr_d = sel_idx;
          alu_mode_d      = req_mode[sel_idx];
          alu_cin_d       = req_cin[sel_idx];
          alu_cmd_d       = req_cmd[32'(sel_idx)*CMD_W +: CMD_W];
          alu_inp_valid_d = req_inp_valid[32'(sel_idx)*2 +: 2];
          alu_opa_d       = req_opa[32'(sel_idx)*DATA_W +: DATA_W];
          alu_opb_d       = req_opb[32'(sel_idx)*DATA_W +: DATA_W];
          alu_ce_d        = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = is_mul(alu_mode_q, 32'(alu_cmd_q)) ? CNT_W'(MUL_LAT - 1) : CNT_W'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_res_d          = alu_res;
          rsp_flags_d        = flags_in;
          rsp_valid_d[id_q]  = 1'b1;
          alu_ce_d           = 1'b0;
          alu_inp_valid_d    = 2'b00;
          state_d            = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      ptr_q           <= IDX_W'(NREQ - 1);
      id_q            <= '0;
      cnt_q           <= '0;
      alu_ce_q        <= 1'b0;
      alu_mode_q      <= 1'b0;
      alu_cin_q       <= 1'b0;
      alu_inp_valid_q <= 2'b00;
      alu_cmd_q       <= '0;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      rsp_valid_q     <= '0;
      rsp_res_q       <= '0;
      rsp_flags_q     <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      id_q            <= id_d;
      cnt_q           <= cnt_d;
      alu_ce_q        <= alu_ce_d;
      alu_mode_q      <= alu_mode_d;
      alu_cin_q       <= alu_cin_d;
      alu_inp_valid_q <= alu_inp_valid_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_res_q       <= rsp_res_d;
      rsp_flags_q     <= rsp_flags_d;
    end
  end

  assign alu_ce        = alu_ce_q;
  assign alu_mode      = alu_mode_q;
  assign alu_cin       = alu_cin_q;
  assign alu_inp_valid = alu_inp_valid_q;
  assign alu_cmd       = alu_cmd_q;
  assign alu_opa       = alu_opa_q;
  assign alu_opb       = alu_opb_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_res       = rsp_res_q;
  assign rsp_flags     = rsp_flags_q;

endmodule
